// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// ----------------
// Clocked transaction front-end for a purely combinational 4-bit ALU.
// It accepts one operation over a valid/ready handshake and registers the
// operands into the ALU. After the ALU has had one full cycle to settle, it
// captures the result and flags. It then presents them downstream over a
// second valid/ready handshake.
//
// FSM: IDLE -> EXEC -> HOLD -> IDLE. Unknown encodings fall back to IDLE.
//
// Optional feature macro: ALU_SEQ_COUNT_EN
//   When it is defined, ops_done counts completed transfers (HOLD->IDLE).
//   The count saturates at 2**CNTW-1.
//   When it is undefined, ops_done is tied to 0.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake (in_ready high only in IDLE)
//   in_a, in_b, in_op      operation presented by upstream
//   alu_a, alu_b, alu_op   registered operands/function driven to the ALU
//   alu_y, alu_cout        combinational ALU result and carry
//   out_valid/out_ready    downstream handshake
//   out_y, out_cout        registered result and carry
//   out_zero               registered zero flag of the captured result
//   busy                   high while in EXEC or HOLD
//   ops_done               completed-op counter (feature macro only)
module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_cout,
    output logic             out_zero,
    output logic             busy,
    output logic [CNTW-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;

`ifdef ALU_SEQ_COUNT_EN
    logic [CNTW-1:0] cnt;
    assign ops_done = cnt;
`else
    assign ops_done = '0;
`endif

    // All handshake and status outputs are registered.
    // This keeps any combinational path from out_ready to out_valid,
    // and from in_valid to in_ready, out of the design.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            out_y     <= '0;
            out_cout  <= 1'b0;
            out_zero  <= 1'b0;
`ifdef ALU_SEQ_COUNT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a    <= in_a;
                        alu_b    <= in_b;
                        alu_op   <= in_op;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                // The ALU inputs have been stable for a full cycle here,
                // so the result is sampled at the end of EXEC.
                EXEC: begin
                    out_y     <= alu_y;
                    out_cout  <= alu_cout;
                    out_zero  <= (alu_y == '0);
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                // The result stays frozen until downstream takes it.
                // The data registers keep their values after the transfer.
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
`ifdef ALU_SEQ_COUNT_EN
                        if (cnt != {CNTW{1'b1}}) begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer.
// It uses a transaction-level reference model, a per-cycle compare process,
// and directed scenarios with literal expectations.
module tb_alu_op_sequencer;

    localparam int WIDTH = 4;
    localparam int OPW   = 4;
    localparam int CNTW  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [OPW-1:0]   in_op = '0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_y;
    logic             out_cout;
    logic             out_zero;
    logic             busy;
    logic [CNTW-1:0]  ops_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_cout(out_cout), .out_zero(out_zero),
        .busy(busy), .ops_done(ops_done)
    );

    // ALU stub: op0 = A+B with carry, op1 = ~A, op2 = A&B, others give 0.
    function automatic logic [WIDTH:0] alu_fn(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [OPW-1:0] op);
        logic [WIDTH:0] r;
        case (op)
            4'h0:    r = {1'b0, a} + {1'b0, b};
            4'h1:    r = {1'b0, ~a};
            4'h2:    r = {1'b0, a & b};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [WIDTH:0] stub_r;
    assign stub_r   = alu_fn(alu_a, alu_b, alu_op);
    assign alu_y    = stub_r[WIDTH-1:0];
    assign alu_cout = stub_r[WIDTH];

    // Reference model.
    // It tracks one operation in flight as the number of edges since it
    // was accepted: -1 means none, 0 means just accepted, 1 means the
    // result is on offer.
    int             m_age = -1;
    bit             m_init = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0, m_y = '0;
    logic [OPW-1:0]   m_op = '0;
    logic             m_c = 1'b0, m_z = 1'b0;
    int             m_cnt = 0;
    logic [WIDTH:0] m_r;

    always @(posedge clk) begin
        if (rst) begin
            m_age = -1; m_a = '0; m_b = '0; m_op = '0;
            m_y = '0; m_c = 1'b0; m_z = 1'b0; m_cnt = 0; m_init = 1;
        end else if (m_age < 0) begin
            if (in_valid) begin
                m_a = in_a; m_b = in_b; m_op = in_op; m_age = 0;
            end
        end else if (m_age == 0) begin
            m_r = alu_fn(m_a, m_b, m_op);
            m_y = m_r[WIDTH-1:0]; m_c = m_r[WIDTH]; m_z = (m_y == 0);
            m_age = 1;
        end else if (out_ready) begin
            m_age = -1;
            if (m_cnt < (1 << CNTW) - 1) m_cnt = m_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_init) begin
            check("in_ready",  int'(in_ready),  (m_age < 0) ? 1 : 0);
            check("busy",      int'(busy),      (m_age >= 0) ? 1 : 0);
            check("out_valid", int'(out_valid), (m_age == 1) ? 1 : 0);
            check("out_y",     int'(out_y),     int'(m_y));
            check("out_cout",  int'(out_cout),  int'(m_c));
            check("out_zero",  int'(out_zero),  int'(m_z));
            check("alu_a",     int'(alu_a),     int'(m_a));
            check("alu_b",     int'(alu_b),     int'(m_b));
            check("alu_op",    int'(alu_op),    int'(m_op));
`ifdef ALU_SEQ_COUNT_EN
            check("ops_done",  int'(ops_done),  m_cnt);
`else
            check("ops_done",  int'(ops_done),  0);
`endif
        end
    end

    // Presents one operation, leaving the bench at the falling edge just
    // after it was accepted (the DUT is then in EXEC).
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset, then idle for three cycles.
        do_reset();
        do_reset();
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_alu_a", int'(alu_a), 0);

        // 9 + 8 = 17 -> y=1, carry 1.
        out_ready = 1'b1;
        send(4'h9, 4'h8, 4'h0);
        check("add_exec_valid", int'(out_valid), 0);
        @(negedge clk);
        check("add_valid", int'(out_valid), 1);
        check("add_y", int'(out_y), 1);
        check("add_cout", int'(out_cout), 1);
        check("add_zero", int'(out_zero), 0);
        @(negedge clk);
        check("add_idle", int'(in_ready), 1);
        check("add_done_valid", int'(out_valid), 0);

        // ~5 = A held under back-pressure; in_valid pulses in HOLD are ignored.
        out_ready = 1'b0;
        send(4'h5, 4'h0, 4'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("not_hold_y", int'(out_y), 4'hA);
            check("not_hold_valid", int'(out_valid), 1);
            in_a = 4'hF; in_b = 4'hF; in_op = 4'h2;
            in_valid = (i % 2 == 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("not_alu_a_kept", int'(alu_a), 5);
        check("not_done_valid", int'(out_valid), 0);

        // 5 & A = 0 -> zero flag.
        send(4'h5, 4'hA, 4'h2);
        @(negedge clk);
        check("and_y", int'(out_y), 0);
        check("and_zero", int'(out_zero), 1);
        check("and_cout", int'(out_cout), 0);
        @(negedge clk);

        // Reset during EXEC.
        out_ready = 1'b0;
        send(4'h1, 4'h1, 4'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_exec_valid", int'(out_valid), 0);
        @(negedge clk);
        check("rst_exec_valid2", int'(out_valid), 0);
        // Reset during HOLD.
        send(4'h2, 4'h2, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_hold_valid", int'(out_valid), 0);
        check("rst_hold_y", int'(out_y), 0);
        out_ready = 1'b1;
        send(4'h3, 4'h4, 4'h0);
        @(negedge clk);
        check("post_rst_y", int'(out_y), 7);
        @(negedge clk);

        // Five back-to-back ops; counter saturates at 3 with CNTW=2.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(4'(i), 4'h1, 4'h0);
            @(negedge clk);
            check("b2b_y", int'(out_y), i + 1);
            @(negedge clk);
`ifdef ALU_SEQ_COUNT_EN
            check("ops_done_seq", int'(ops_done), (i < 3) ? i + 1 : 3);
`else
            check("ops_done_off", int'(ops_done), 0);
`endif
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
